usb_rx_pkt_ctrl: RTL

//  Downstream of the USB 1.1 receiver: drains its RX FIFO, classifies each packet by PID, and CRC16-checks DATA0/DATA1.

---
 rtl/usb_rx_pkt_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/usb_rx_pkt_ctrl.sv
// usb_rx_pkt_ctrl: drains the USB RX FIFO, classifies by PID, CRC16-checks DATA packets and forwards payload with per-packet status.
module usb_rx_pkt_ctrl #(
   parameter int MAX_LEN = 64,
   parameter int LEN_W   = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rcving,
   input  logic             r_error,
   input  logic [3:0]       PID,
   input  logic             empty,
   input  logic [7:0]       r_data,
   output logic             r_enable,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             pkt_done,
   output logic             pkt_ok,
   output logic [2:0]       pkt_status,
   output logic [LEN_W-1:0] pkt_len,
   output logic             data_toggle
);
   typedef enum logic [2:0] {S_IDLE, S_CLASSIFY, S_DATA, S_FLUSH, S_DONE} state_t;
   state_t r_state, w_next;
   logic [15:0]      r_crc;
   logic [1:0]       r_cnt;
   logic [1:0]       r_hcnt;
   logic [7:0]       r_hold [2];
   logic [7:0]       r_out_data;
   logic             r_out_valid;
   logic [LEN_W-1:0] r_fwd;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_pkt_len;
   logic [2:0]       r_status;
   logic             r_ok;
   logic             r_toggle;
   logic             r_err;
   logic             r_long;
   logic             w_drop;
   logic             w_pop;
   logic             w_shift;
   logic             w_load;
   logic [2:0]       w_status;

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] x;
      x = c;
      for (int i = 0; i < 8; i++) x = (x >> 1) ^ ((x[0] ^ b[i]) ? 16'hA001 : 16'h0000);
      return x;
   endfunction

   // Once MAX_LEN bytes have been forwarded, further shift-outs are dropped so popping never stalls.
   assign w_drop   = (r_fwd == LEN_W'(MAX_LEN));
   assign w_pop    = ~empty & ((r_state == S_FLUSH) |
                     ((r_state == S_DATA) & ((r_hcnt != 2'd2) | w_drop | ~r_out_valid | out_ready)));
   assign w_shift  = w_pop & (r_state == S_DATA) & (r_hcnt == 2'd2);
   assign w_load   = w_shift & ~w_drop;
   assign w_status = (r_err | r_error) ? 3'd2 :
                     (r_state == S_FLUSH) ? 3'd5 :
                     (r_cnt < 2'd2) ? 3'd3 :
                     r_long ? 3'd4 :
                     (r_crc != 16'hB001) ? 3'd1 : 3'd0;

   assign r_enable    = w_pop;
   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign pkt_done    = (r_state == S_DONE);
   assign pkt_ok      = r_ok;
   assign pkt_status  = r_status;
   assign pkt_len     = r_pkt_len;
   assign data_toggle = r_toggle;

   always_ff @(posedge clk)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (rcving) w_next = S_CLASSIFY;
         S_CLASSIFY: if (!empty || !rcving) w_next = (PID[2:0] == 3'b011) ? S_DATA : S_FLUSH;
         S_DATA:     if (!rcving && empty && !r_out_valid) w_next = S_DONE;
         S_FLUSH:    if (!rcving && empty) w_next = S_DONE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_crc       <= 16'hFFFF;
         r_cnt       <= '0;
         r_hcnt      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_fwd       <= '0;
         r_len       <= '0;
         r_pkt_len   <= '0;
         r_status    <= '0;
         r_ok        <= 1'b0;
         r_toggle    <= 1'b0;
         r_err       <= 1'b0;
         r_long      <= 1'b0;
      end else begin
         if (r_state == S_IDLE) begin
            r_crc  <= 16'hFFFF;
            r_cnt  <= '0;
            r_hcnt <= '0;
            r_fwd  <= '0;
            r_len  <= '0;
            r_err  <= 1'b0;
            r_long <= 1'b0;
         end else begin
            if (r_error) r_err <= 1'b1;
            if (w_pop && r_state == S_DATA) begin
               r_crc <= crc_byte(r_crc, r_data);
               if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
               if (r_hcnt != 2'd2) begin
                  r_hold[r_hcnt[0]] <= r_data;
                  r_hcnt            <= r_hcnt + 2'd1;
               end else begin
                  r_hold[0] <= r_hold[1];
                  r_hold[1] <= r_data;
               end
            end
            if (w_shift && w_drop) r_long <= 1'b1;
         end
         if (w_load) begin
            r_out_data  <= r_hold[0];
            r_out_valid <= 1'b1;
            r_fwd       <= r_fwd + 1'b1;
         end else if (out_ready) r_out_valid <= 1'b0;
         if (r_out_valid && out_ready && r_len != '1) r_len <= r_len + 1'b1;
         if (r_state == S_CLASSIFY && w_next == S_DATA) r_toggle <= PID[3];
         if (w_next == S_DONE && r_state != S_DONE) begin
            r_status  <= w_status;
            r_ok      <= (w_status == 3'd0);
            r_pkt_len <= r_len;
         end
      end
   end
endmodule
